// File: rtl/tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter_pkg
// Purpose  : Shared defaults, FSM encoding and counter width for tx_arbiter.
// Revision : 1.0
// ============================================================================
package tx_arbiter_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter_if
// Purpose  : Granted-word handshake between tx_arbiter and the downstream mux.
// Revision : 1.0
// ============================================================================
interface tx_arbiter_if
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int CH_W = $clog2(NUM_CH);

  logic              tx_dv_out;
  logic [DATA_W-1:0] tx_data;
  logic [CH_W-1:0]   tx_chan;
  logic              tx_ready;

  modport master (output tx_dv_out, output tx_data, output tx_chan, input tx_ready);
  modport slave  (input tx_dv_out, input tx_data, input tx_chan, output tx_ready);

endinterface
`default_nettype wire

// File: rtl/tx_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_select
// Purpose  : Combinational round-robin pick, searching upward from last_grant+1.
// Revision : 1.0
// ============================================================================
module rr_select
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   grant,
  output logic              any
);

  always_comb begin
    int idx;
    grant = '0;
    any   = |pending;
    // Walk from the farthest offset back to the nearest so the nearest hit wins.
    for (int off = NUM_CH; off >= 1; off--) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (pending[CH_W'(idx)]) grant = CH_W'(idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter
// Purpose  : Per-channel one-deep holding, round-robin grant to a ready/valid tx.
// Revision : 1.0
// ============================================================================
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_dv,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  input  logic                     ovf_clr,
  output logic [NUM_CH-1:0]        ovf,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  tx_arbiter_if.master             tx
);

  localparam int CH_W = $clog2(NUM_CH);

  arb_state_t                     state;
  logic [CH_W-1:0]                last_grant;
  logic [NUM_CH-1:0]              pending;
  logic [NUM_CH-1:0][DATA_W-1:0]  hold;

  logic [NUM_CH-1:0]              clear_mask;
  logic [NUM_CH-1:0]              capture_mask;
  logic [NUM_CH-1:0]              drop_mask;
  logic [DROP_CNT_W:0]            drop_k;
  logic [DROP_CNT_W:0]            drop_sum;
  logic [CH_W-1:0]                rr_grant;
  logic                           rr_any;

  rr_select #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_select (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .any        (rr_any)
  );

  // A channel being accepted this cycle can take a fresh word without overflowing.
  always_comb begin
    clear_mask = '0;
    if (state == SEND && tx.tx_ready) clear_mask[tx.tx_chan] = 1'b1;
    capture_mask = req_dv & (~pending | clear_mask);
    drop_mask    = req_dv & pending & ~clear_mask;
    drop_k       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_k = drop_k + {{DROP_CNT_W{1'b0}}, drop_mask[i]};
    end
    drop_sum = (ovf_clr ? {(DROP_CNT_W+1){1'b0}} : {1'b0, drop_cnt}) + drop_k;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      hold     <= '0;
      ovf      <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= (pending & ~clear_mask) | capture_mask;
      ovf      <= (ovf_clr ? {NUM_CH{1'b0}} : ovf) | drop_mask;
      drop_cnt <= drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture_mask[i]) hold[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= CH_W'(NUM_CH - 1);
      tx.tx_dv_out <= 1'b0;
      tx.tx_data   <= '0;
      tx.tx_chan   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_any) begin
            tx.tx_data   <= hold[rr_grant];
            tx.tx_chan   <= rr_grant;
            tx.tx_dv_out <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (tx.tx_ready) begin
            tx.tx_dv_out <= 1'b0;
            last_grant   <= tx.tx_chan;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_arbiter
// Purpose  : Directed bench with a cycle model of tx_arbiter checked every cycle.
// Revision : 1.0
// ============================================================================
module tb_tx_arbiter;
  import tx_arbiter_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  req_dv;
  logic [NCH*DW-1:0] req_data;
  logic            ovf_clr;
  logic [NCH-1:0]  ovf;
  logic [15:0]     drop_cnt;

  tx_arbiter_if #(.NUM_CH(NCH), .DATA_W(DW)) txb ();

  tx_arbiter #(.NUM_CH(NCH), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_dv   (req_dv),
    .req_data (req_data),
    .ovf_clr  (ovf_clr),
    .ovf      (ovf),
    .drop_cnt (drop_cnt),
    .tx       (txb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model state: held words, pending flags, the word on offer, overflow bookkeeping.
  logic [DW-1:0]  m_hold [NCH];
  logic [NCH-1:0] m_pend = '0;
  logic [NCH-1:0] m_ovf  = '0;
  logic [DW-1:0]  m_data = '0;
  bit             m_dv   = 1'b0;
  int             m_chan = 0;
  int             m_last = NCH - 1;
  int             m_drop = 0;
  int             m_drops;
  int             m_g;
  bit             m_found;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = '0; m_ovf = '0; m_data = '0; m_dv = 1'b0;
      m_chan = 0;  m_last = NCH - 1; m_drop = 0;
    end else begin
      m_drops = 0;
      if (m_dv) begin
        if (txb.tx_ready) begin
          m_pend[m_chan] = 1'b0;
          m_last = m_chan;
          m_dv = 1'b0;
        end
      end else begin
        m_found = 1'b0;
        for (int off = 1; off <= NCH; off++) begin
          m_g = (m_last + off) % NCH;
          if (!m_found && m_pend[m_g]) begin
            m_found = 1'b1;
            m_dv = 1'b1;
            m_chan = m_g;
            m_data = m_hold[m_g];
          end
        end
      end
      if (ovf_clr) begin
        m_ovf = '0;
        m_drop = 0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (req_dv[i]) begin
          if (!m_pend[i]) begin
            m_hold[i] = req_data[i*DW +: DW];
            m_pend[i] = 1'b1;
          end else begin
            m_ovf[i] = 1'b1;
            m_drops++;
          end
        end
      end
      m_drop = m_drop + m_drops;
      if (m_drop > 65535) m_drop = 65535;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_dv", txb.tx_dv_out, m_dv);
      if (m_dv) begin
        chk("m_chan", txb.tx_chan, m_chan);
        chk("m_data", txb.tx_data, m_data);
      end
      chk("m_ovf", ovf, m_ovf);
      chk("m_drop", drop_cnt, m_drop);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input int ch, input logic [DW-1:0] d);
    req_data[ch*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_dv = '0; ovf_clr = 1'b0; txb.tx_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  int seen;

  initial begin
    reset = 1'b1; req_dv = '0; req_data = '0; ovf_clr = 1'b0; txb.tx_ready = 1'b0;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_dv", txb.tx_dv_out, 0);
    chk("rst_data", txb.tx_data, 0);
    chk("rst_chan", txb.tx_chan, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b0;

    // Single channel, two-cycle latency, held for one cycle.
    txb.tx_ready = 1'b1; req_dv = 4'b0100; put(2, 32'h0000_00A5);
    tick(); req_dv = '0;
    tick();
    chk("single_dv", txb.tx_dv_out, 1);
    chk("single_chan", txb.tx_chan, 2);
    chk("single_data", txb.tx_data, 32'hA5);
    tick();
    chk("single_dv_low", txb.tx_dv_out, 0);

    // Round robin from reset: 0,1,2,3 every two cycles.
    do_reset();
    txb.tx_ready = 1'b1; req_dv = '1;
    for (int i = 0; i < NCH; i++) put(i, 32'h10 + i);
    tick(); req_dv = '0;
    for (int k = 0; k < NCH; k++) begin
      tick();
      chk("rr_dv", txb.tx_dv_out, 1);
      chk("rr_chan", txb.tx_chan, k);
      chk("rr_data", txb.tx_data, 32'h10 + k);
      tick();
      chk("rr_gap", txb.tx_dv_out, 0);
    end

    // Backpressure: five stalled cycles, then accepted.
    do_reset();
    req_dv = 4'b0010; put(1, 32'h1234);
    tick(); req_dv = '0;
    tick();
    chk("bp_dv", txb.tx_dv_out, 1);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("bp_hold_dv", txb.tx_dv_out, 1);
      chk("bp_hold_chan", txb.tx_chan, 1);
      chk("bp_hold_data", txb.tx_data, 32'h1234);
    end
    txb.tx_ready = 1'b1;
    tick();
    chk("bp_accepted", txb.tx_dv_out, 0);

    // Overflow on channel 3, then clear.
    do_reset();
    req_dv = 4'b1000; put(3, 32'h7);
    tick(); req_dv = '0;
    tick();
    chk("ovf_first_data", txb.tx_data, 32'h7);
    req_dv = 4'b1000; put(3, 32'h8);
    tick(); req_dv = '0;
    chk("ovf_flag", ovf, 4'b1000);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_kept_data", txb.tx_data, 32'h7);
    txb.tx_ready = 1'b1;
    tick();
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    chk("ovf_clr_flag", ovf, 0);
    chk("ovf_clr_drop", drop_cnt, 0);

    // Four simultaneous drops, then drops concurrent with a clear.
    txb.tx_ready = 1'b0; req_dv = '1;
    tick(); req_dv = '0;
    tick(); req_dv = '1;
    tick(); req_dv = '0;
    chk("multi_drop", drop_cnt, 4);
    chk("multi_ovf", ovf, 4'hF);
    req_dv = '1; ovf_clr = 1'b1;
    tick(); req_dv = '0; ovf_clr = 1'b0;
    chk("clr_vs_drop_cnt", drop_cnt, 4);
    chk("clr_vs_drop_ovf", ovf, 4'hF);

    // Same-cycle refill on the acceptance cycle.
    do_reset();
    txb.tx_ready = 1'b1; req_dv = 4'b0001; put(0, 32'h44);
    tick(); req_dv = '0;
    tick();
    chk("refill_first", txb.tx_data, 32'h44);
    req_dv = 4'b0001; put(0, 32'h55);
    tick(); req_dv = '0;
    chk("refill_gap", txb.tx_dv_out, 0);
    chk("refill_no_ovf", ovf, 0);
    tick();
    chk("refill_dv", txb.tx_dv_out, 1);
    chk("refill_chan", txb.tx_chan, 0);
    chk("refill_data", txb.tx_data, 32'h55);

    // Reset mid-SEND abandons the word; req_dv during reset is ignored.
    do_reset();
    req_dv = 4'b0010; put(1, 32'h99);
    tick(); req_dv = '0;
    tick();
    chk("midrst_dv_pre", txb.tx_dv_out, 1);
    reset = 1'b1; req_dv = '1;
    tick(); reset = 1'b0; req_dv = '0;
    chk("midrst_dv", txb.tx_dv_out, 0);
    chk("midrst_data", txb.tx_data, 0);
    chk("midrst_chan", txb.tx_chan, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_drop", drop_cnt, 0);
    txb.tx_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      tick();
      seen += int'(txb.tx_dv_out);
    end
    chk("midrst_none", seen, 0);

    // Drop counter saturation.
    txb.tx_ready = 1'b0; req_dv = '1;
    repeat (16400) tick();
    req_dv = '0;
    tick();
    chk("sat_drop", drop_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
